// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between the execute stage (req0) and the branch/AGU (req1).
// Define ALU_ARB_ILLEGAL_CHK_EN to trap unsupported selects into an err-flagged response.
module alu_share_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_sel,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_sel,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_result,
    output logic         rsp0_zero,
    output logic         rsp0_err,

    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_result,
    output logic         rsp1_zero,
    output logic         rsp1_err,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_flag
);

    // state      | meaning
    // SLOT_EMPTY | response register holds no result for its requester
    // SLOT_FULL  | response register holds a result awaiting rspX_ready

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t slot0_q, slot0_d;
    slot_state_t slot1_q, slot1_d;
    logic        last_grant_q, last_grant_d;

    logic [N-1:0] rsp0_result_q, rsp1_result_q;
    logic         rsp0_zero_q, rsp1_zero_q;

    logic         free0, free1;
    logic         elig0, elig1;
    logic         grant0, grant1;
    logic [3:0]   win_sel;
    logic         illegal;
    logic [N-1:0] cap_result;
    logic         cap_zero;

    // A slot draining this cycle can be refilled in the same cycle.
    always_comb begin
        free0  = (slot0_q == SLOT_EMPTY) || rsp0_ready;
        free1  = (slot1_q == SLOT_EMPTY) || rsp1_ready;
        elig0  = !rst && req0_valid && free0;
        elig1  = !rst && req1_valid && free1;
        grant0 = elig0 && (!elig1 || last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        win_sel = SEL_ADD;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            win_sel = req0_sel;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            win_sel = req1_sel;
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    always_comb begin
        illegal = 1'b0;
        if (grant0 || grant1) begin
            case (win_sel)
                SEL_AND, SEL_OR, SEL_ADD, SEL_SUB: illegal = 1'b0;
                default:                           illegal = 1'b1;
            endcase
        end
    end
    assign alu_sel = illegal ? SEL_ADD : win_sel;
`else
    assign illegal = 1'b0;
    assign alu_sel = win_sel;
`endif

    // Illegal ops still produce a response, but with a cleared result and flag.
    assign cap_result = illegal ? '0 : alu_result;
    assign cap_zero   = illegal ? 1'b0 : alu_flag;

    always_comb begin
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        last_grant_d = last_grant_q;

        if (grant0) begin
            slot0_d = SLOT_FULL;
        end else if ((slot0_q == SLOT_FULL) && rsp0_ready) begin
            slot0_d = SLOT_EMPTY;
        end

        if (grant1) begin
            slot1_d = SLOT_FULL;
        end else if ((slot1_q == SLOT_FULL) && rsp1_ready) begin
            slot1_d = SLOT_EMPTY;
        end

        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q       <= SLOT_EMPTY;
            slot1_q       <= SLOT_EMPTY;
            last_grant_q  <= 1'b1;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            last_grant_q <= last_grant_d;
            if (grant0) begin
                rsp0_result_q <= cap_result;
                rsp0_zero_q   <= cap_zero;
            end
            if (grant1) begin
                rsp1_result_q <= cap_result;
                rsp1_zero_q   <= cap_zero;
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic rsp0_err_q, rsp1_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_err_q <= 1'b0;
            rsp1_err_q <= 1'b0;
        end else begin
            if (grant0) rsp0_err_q <= illegal;
            if (grant1) rsp1_err_q <= illegal;
        end
    end

    assign rsp0_err = rsp0_err_q;
    assign rsp1_err = rsp1_err_q;
`else
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    assign rsp0_valid  = (slot0_q == SLOT_FULL);
    assign rsp1_valid  = (slot1_q == SLOT_FULL);
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_sel, req1_sel;
    logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [N-1:0] rsp0_result, rsp1_result;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_sel;
    logic         alu_flag;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_flag = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_sel = 4'b0010;
        req1_valid = 1'b1; req1_a = 32'h2; req1_b = 32'h2; req1_sel = 4'b0010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // reset with requests pending: nothing granted or captured
        tick();
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp0_err", {31'b0, rsp0_err}, 32'd0);

        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("idle_alu_sel", {28'b0, alu_sel}, 32'h2);
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_req0_ready", {31'b0, req0_ready}, 32'd0);

        // single ADD on req0
        tick();
        req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_sel = 4'b0010;
        #1;
        chk("add_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("add_alu_a", alu_a, 32'h5);
        tick();
        req0_valid = 1'b0;
        chk("add_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("add_rsp0_result", rsp0_result, 32'h8);
        chk("add_rsp0_zero", {31'b0, rsp0_zero}, 32'd0);
        tick();
        chk("add_drain", {31'b0, rsp0_valid}, 32'd0);

        // SUB to zero then wrap on req1, back-to-back through a draining slot
        req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'h12345678; req1_sel = 4'b0110;
        #1;
        chk("sub_req1_ready", {31'b0, req1_ready}, 32'd1);
        tick();
        chk("sub_rsp1_result", rsp1_result, 32'h0);
        chk("sub_rsp1_zero", {31'b0, rsp1_zero}, 32'd1);
        req1_a = 32'h0; req1_b = 32'h1;
        #1;
        chk("wrap_req1_ready", {31'b0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("wrap_rsp1_result", rsp1_result, 32'hFFFFFFFF);
        chk("wrap_rsp1_zero", {31'b0, rsp1_zero}, 32'd0);
        tick();
        chk("wrap_drain", {31'b0, rsp1_valid}, 32'd0);

        // contention from reset: grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hF0F0F0F0; req0_b = 32'h0FF00FF0; req0_sel = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'hF0F0F0F0; req1_b = 32'h0FF00FF0; req1_sel = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_req0_ready", i), {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_req1_ready", i), {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i % 2 == 0) chk($sformatf("rr%0d_rsp0_result", i), rsp0_result, 32'h00F000F0);
            else            chk($sformatf("rr%0d_rsp1_result", i), rsp1_result, 32'hFFF0FFF0);
        end

        // backpressure on rsp0: req0 wins once, then req1 streams while rsp0 holds
        rsp0_ready = 1'b0;
        #1;
        chk("bp_first_req0_ready", {31'b0, req0_ready}, 32'd1);
        tick();
        req0_a = 32'h1; req0_b = 32'h1; req0_sel = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_req0_ready", i), {31'b0, req0_ready}, 32'd0);
            chk($sformatf("bp%0d_req1_ready", i), {31'b0, req1_ready}, 32'd1);
            tick();
            chk($sformatf("bp%0d_rsp0_result", i), rsp0_result, 32'h00F000F0);
            chk($sformatf("bp%0d_rsp1_valid", i), {31'b0, rsp1_valid}, 32'd1);
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("bp_release_req1_ready", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("bp_release_rsp0_result", rsp0_result, 32'h2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

`ifdef ALU_ARB_ILLEGAL_CHK_EN
        req0_valid = 1'b1; req0_a = 32'h7; req0_b = 32'h9; req0_sel = 4'b1111;
        #1;
        chk("ill_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("ill_alu_sel", {28'b0, alu_sel}, 32'h2);
        tick();
        chk("ill_rsp0_err", {31'b0, rsp0_err}, 32'd1);
        chk("ill_rsp0_result", rsp0_result, 32'd0);
        chk("ill_rsp0_zero", {31'b0, rsp0_zero}, 32'd0);
        req0_sel = 4'b0010;
        tick();
        req0_valid = 1'b0;
        chk("ill_clear_err", {31'b0, rsp0_err}, 32'd0);
        chk("ill_clear_result", rsp0_result, 32'h10);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters: requester 0 is the execute stage, requester 1 is the branch/address-generation unit.
- Uses round-robin arbitration with a valid/ready request handshake.
- Drives the ALU operand and select inputs, and captures the ALU result and zero flag.
- Returns each response through a one-deep per-requester response register with valid/ready handshake.
- Sits between the core pipeline and the ALU.

Parameters:
- N, 32, datapath width of operands and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  N  operand A.
- req0_b  input  N  operand B.
- req0_sel  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as above, for requester 1.
- rsp0_valid  output  1  response register 0 holds a result.
- rsp0_ready  input  1  requester 0 consumes its response.
- rsp0_result  output  N  captured ALU result.
- rsp0_zero  output  1  captured ALU zero flag.
- rsp0_err  output  1  illegal-op indication (see Optional Feature).
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_err  same as above, for requester 1.
- alu_a  output  N  ALU operand A.
- alu_b  output  N  ALU operand B.
- alu_sel  output  4  ALU select.
- alu_result  input  N  ALU result.
- alu_flag  input  1  ALU zero flag.

Behaviour:
- Reset (rst high at a clock edge):
  - rspX_valid=0, rspX_result=0, rspX_zero=0, rspX_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - While rst is high, reqX_ready=0.
- Slot state per requester: EMPTY when rspX_valid=0, FULL when rspX_valid=1.
  - A slot is "free" if EMPTY, or FULL with rspX_ready=1 in the same cycle (drain and refill in one cycle).
- Eligibility: requester X is eligible when reqX_valid=1 and its slot is free.
- Arbitration (combinational within the cycle):
  - One eligible requester: it is granted.
  - Both eligible: grant goes to the requester other than last_grant.
  - None eligible: no grant.
  - reqX_ready = grant to X. At most one ready is high per cycle.
- Datapath muxing:
  - On a grant, alu_a/alu_b/alu_sel carry the winner's operands and select, combinationally in the same cycle.
  - With no grant: alu_a=0, alu_b=0, alu_sel=0010, so the ALU never sees an undefined select.
- Capture (at the edge ending a grant cycle):
  - rspX_result <= alu_result, rspX_zero <= alu_flag, rspX_valid <= 1.
  - last_grant <= X.
  - Latency: request accepted in cycle T, rspX_valid=1 in cycle T+1.
- Drain: in a cycle with rspX_valid=1 and rspX_ready=1 and no new grant to X, rspX_valid <= 0 at the edge.
  - rspX_result and rspX_zero hold their stale values when the slot is EMPTY.
- Hold: while rspX_valid=1 and rspX_ready=0, rspX_result/zero/err are stable and X is not eligible.
- Fairness: with both requesters continuously valid and both responses drained every cycle, grants alternate 0,1,0,1...
- Independence: a stalled requester (rspX_ready=0) never blocks the other requester.
- Arithmetic: ADD and SUB wrap modulo 2^N; no carry or overflow is reported.
- Operands are passed through unchanged; the ALU performs the negation for SUB.
- Reset mid-operation: a grant in the same cycle as rst is discarded; no response is produced.
- Request inputs are sampled only in the grant cycle. Requesters must hold operands stable while valid and not ready.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_CHK_EN
- Defined:
  - A request whose reqX_sel is not in {0000, 0001, 0010, 0110} is still granted normally.
  - alu_sel is forced to 0010 for that cycle.
  - The captured response is rspX_result=0, rspX_zero=0, rspX_err=1.
  - rspX_err is cleared on the next legal capture.
- Not defined:
  - reqX_sel is forwarded unchanged to alu_sel.
  - rspX_err is tied 0.
  - The response for an illegal select is unspecified.

Test Plan:
- Reset then idle: rst high for 2 cycles → all rsp*_valid=0, req*_ready=0 during rst; after release with no valid inputs, alu_sel=0010, alu_a=0.
- Single ADD: req0 a=0x00000005 b=0x00000003 sel=0010 with rsp0_ready=1 → req0_ready=1 in cycle T; rsp0_valid=1, rsp0_result=0x00000008, rsp0_zero=0 in T+1.
- SUB to zero on req1: a=b=0x12345678 sel=0110 → rsp1_result=0x00000000, rsp1_zero=1; a=0, b=1 sel=0110 → rsp1_result=0xFFFFFFFF (wrap).
- Contention: both valid for 4 cycles from reset, both rsp_ready=1 → grant order 0,1,0,1; results AND/OR of 0xF0F0F0F0, 0x0FF00FF0 give 0x00F000F0 and 0xFFF0FFF0.
- Backpressure: rsp0_ready=0 with rsp0 FULL, both requesters valid → req0_ready=0; req1 granted every cycle; rsp0_result stable. Raising rsp0_ready → req0 is granted in that same cycle.
- With ALU_ARB_ILLEGAL_CHK_EN defined: req0 sel=1111 → alu_sel=0010 in the grant cycle; rsp0_err=1, rsp0_result=0. A following legal ADD clears rsp0_err.
